// File: rtl/ocr_pkg.sv
// Shared definitions for the inverse-time overcurrent trip timer:
// FSM encoding, band numbering, threshold unit and the band increment table.
package ocr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CAPTURE  = 2'd1,
    ST_CLASSIFY = 2'd2,
    ST_UPDATE   = 2'd3
  } state_e;

  // Bands 0..5: 0 is below pick-up, 5 is at or above 8x pick-up.
  localparam int BAND_CNT    = 6;
  localparam int BAND_W      = 3;
  // One trip unit of accumulator per step of the time multiplier.
  localparam int THRESH_UNIT = 64;
  localparam int INCR_W      = 7;

  typedef logic [BAND_W-1:0] band_t;

  // Accumulator increment per band; grows steeply so heavy faults trip fast.
  function automatic logic [INCR_W-1:0] band_incr(input band_t band);
    logic [INCR_W-1:0] incr;
    case (band)
      3'd1:    incr = 7'd1;
      3'd2:    incr = 7'd3;
      3'd3:    incr = 7'd8;
      3'd4:    incr = 7'd20;
      3'd5:    incr = 7'd64;
      default: incr = 7'd0;
    endcase
    return incr;
  endfunction

endpackage

// File: rtl/idmt_trip_timer_if.sv
// Bundle of the RMS-result input side and the trip/status output side.
interface idmt_trip_timer_if #(
  parameter int TMS_W = 4,
  parameter int ACC_W = 16
);
  logic             rms_valid;
  logic [15:0]      rms_value;
  logic [15:0]      I_p;
  logic [TMS_W-1:0] tms;
  logic             trip_ack;
  logic             trip_signal;
  logic             pickup;
  logic [ACC_W-1:0] accum;
  logic             busy;
  logic             overrun;

  // Driver of RMS results and acknowledges; observer of the trip status.
  modport master (
    output rms_valid, rms_value, I_p, tms, trip_ack,
    input  trip_signal, pickup, accum, busy, overrun
  );

  // The trip timer itself.
  modport slave (
    input  rms_valid, rms_value, I_p, tms, trip_ack,
    output trip_signal, pickup, accum, busy, overrun
  );
endinterface

// File: rtl/ocr_band_classify.sv
// Combinational overcurrent band classifier. Compares the RMS value
// against multiples of the pick-up current in 19 bits so 8x never overflows.
module ocr_band_classify
  import ocr_pkg::*;
(
  input  logic [15:0] rms,
  input  logic [15:0] i_p,
  output band_t       band
);

  logic [18:0] rms_w;
  logic [18:0] ip_x1;
  logic [18:0] ip_x15;
  logic [18:0] ip_x2;
  logic [18:0] ip_x4;
  logic [18:0] ip_x8;

  // Threshold multiples of pick-up; 1.5x uses the truncating I_p + I_p/2 form.
  always_comb begin
    rms_w  = {3'b000, rms};
    ip_x1  = {3'b000, i_p};
    ip_x15 = ip_x1 + (ip_x1 >> 3'd1);
    ip_x2  = ip_x1 << 3'd1;
    ip_x4  = ip_x1 << 3'd2;
    ip_x8  = ip_x1 << 3'd3;
  end

  // Highest band whose threshold is met; a zero pick-up never classifies as fault.
  always_comb begin
    band = 3'd0;
    if (i_p == 16'd0) begin
      band = 3'd0;
    end else if (rms_w >= ip_x8) begin
      band = 3'd5;
    end else if (rms_w >= ip_x4) begin
      band = 3'd4;
    end else if (rms_w >= ip_x2) begin
      band = 3'd3;
    end else if (rms_w >= ip_x15) begin
      band = 3'd2;
    end else if (rms_w >= ip_x1) begin
      band = 3'd1;
    end else begin
      band = 3'd0;
    end
  end

endmodule

// File: rtl/idmt_trip_timer.sv
// Inverse-definite-minimum-time trip timer. Each accepted RMS window walks
// IDLE -> CAPTURE -> CLASSIFY -> UPDATE; the window's band feeds a saturating
// accumulator that latches a trip once it reaches (tms+1)*64.
module idmt_trip_timer
  import ocr_pkg::*;
#(
  parameter int TMS_W     = 4,
  parameter int ACC_W     = 16,
  parameter int RESET_DEC = 4
) (
  input  logic            clk_master,
  input  logic            reset,
  idmt_trip_timer_if.slave bus
);

  localparam logic [ACC_W-1:0] ACC_MAX = {ACC_W{1'b1}};
  localparam logic [ACC_W-1:0] DEC_V   = ACC_W'(RESET_DEC);

  state_e           state_q,   state_d;
  logic [15:0]      rms_q,     rms_d;
  logic [15:0]      ip_q,      ip_d;
  logic [TMS_W-1:0] tms_q,     tms_d;
  band_t            band_q,    band_d;
  logic [ACC_W-1:0] accum_q,   accum_d;
  logic             pickup_q,  pickup_d;
  logic             trip_q,    trip_d;
  logic             busy_q,    busy_d;
  logic             overrun_q, overrun_d;

  band_t            band_s;
  logic [ACC_W:0]   sum_s;
  logic [ACC_W-1:0] acc_new_s;
  logic [31:0]      thresh_s;

  ocr_band_classify u_classify (
    .rms  (rms_q),
    .i_p  (ip_q),
    .band (band_s)
  );

  // New accumulator value for the classified band: saturating add or floored decay.
  always_comb begin
    sum_s     = {1'b0, accum_q} + (ACC_W+1)'(band_incr(band_q));
    acc_new_s = accum_q;
    if (band_q == 3'd0) begin
      if (accum_q >= DEC_V) begin
        acc_new_s = accum_q - DEC_V;
      end else begin
        acc_new_s = '0;
      end
    end else if (sum_s[ACC_W]) begin
      acc_new_s = ACC_MAX;
    end else begin
      acc_new_s = sum_s[ACC_W-1:0];
    end
    thresh_s = (32'(tms_q) + 32'd1) * 32'(THRESH_UNIT);
  end

  // Next-state and datapath control; acknowledge overrides any window activity.
  always_comb begin
    state_d   = state_q;
    rms_d     = rms_q;
    ip_d      = ip_q;
    tms_d     = tms_q;
    band_d    = band_q;
    accum_d   = accum_q;
    pickup_d  = pickup_q;
    trip_d    = trip_q;
    overrun_d = overrun_q;
    if (bus.trip_ack) begin
      state_d  = ST_IDLE;
      accum_d  = '0;
      pickup_d = 1'b0;
      trip_d   = 1'b0;
    end else begin
      if (bus.rms_valid && (state_q != ST_IDLE)) begin
        overrun_d = 1'b1;
      end else begin
        overrun_d = overrun_q;
      end
      case (state_q)
        ST_IDLE: begin
          if (bus.rms_valid) begin
            state_d = ST_CAPTURE;
            rms_d   = bus.rms_value;
            ip_d    = bus.I_p;
            tms_d   = bus.tms;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_CAPTURE: begin
          band_d  = band_s;
          state_d = ST_CLASSIFY;
        end
        // The window result is committed on the edge into UPDATE so it is
        // visible for the whole UPDATE cycle, three cycles after the strobe.
        ST_CLASSIFY: begin
          accum_d  = acc_new_s;
          pickup_d = (band_q != 3'd0);
          trip_d   = trip_q | (32'(acc_new_s) >= thresh_s);
          state_d  = ST_UPDATE;
        end
        ST_UPDATE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk_master) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      rms_q     <= 16'd0;
      ip_q      <= 16'd0;
      tms_q     <= '0;
      band_q    <= 3'd0;
      accum_q   <= '0;
      pickup_q  <= 1'b0;
      trip_q    <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rms_q     <= rms_d;
      ip_q      <= ip_d;
      tms_q     <= tms_d;
      band_q    <= band_d;
      accum_q   <= accum_d;
      pickup_q  <= pickup_d;
      trip_q    <= trip_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
    end
  end

  assign bus.trip_signal = trip_q;
  assign bus.pickup      = pickup_q;
  assign bus.accum       = accum_q;
  assign bus.busy        = busy_q;
  assign bus.overrun     = overrun_q;

endmodule

// File: tb/tb_idmt_trip_timer.sv
// Self-checking bench for idmt_trip_timer: a window-level reference model
// predicts every output each cycle; directed sequences pin literal values.
module tb_idmt_trip_timer;

  localparam int TMS_W     = 4;
  localparam int ACC_W     = 16;
  localparam int RESET_DEC = 4;
  localparam int ACC_MAXI  = (1 << ACC_W) - 1;

  logic clk_master = 1'b0;
  logic reset;

  idmt_trip_timer_if #(.TMS_W(TMS_W), .ACC_W(ACC_W)) bus ();

  idmt_trip_timer #(.TMS_W(TMS_W), .ACC_W(ACC_W), .RESET_DEC(RESET_DEC)) dut (
    .clk_master (clk_master),
    .reset      (reset),
    .bus        (bus)
  );

  always #5 clk_master = ~clk_master;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model (window-level) ----------------
  int     incr_tab [6] = '{0, 1, 3, 8, 20, 64};
  int     m_accum  = 0;
  logic   m_trip   = 1'b0;
  logic   m_pickup = 1'b0;
  logic   m_over   = 1'b0;
  logic   m_busy   = 1'b0;
  logic   m_win    = 1'b0;
  longint m_cyc    = 0;
  longint m_acc_cyc = 0;
  int     w_rms, w_ip, w_tms;

  function automatic int model_band(input int r, input int p);
    if (p == 0) return 0;
    if (r >= 8 * p) return 5;
    if (r >= 4 * p) return 4;
    if (r >= 2 * p) return 3;
    if (r >= p + p / 2) return 2;
    if (r >= p) return 1;
    return 0;
  endfunction

  // A window accepted at edge a resolves at edge a+2 and keeps busy through edge a+3.
  always @(posedge clk_master) begin : ref_model
    logic busy_now;
    int   b;
    m_cyc = m_cyc + 1;
    if (!reset) begin
      m_accum = 0; m_trip = 1'b0; m_pickup = 1'b0; m_over = 1'b0; m_win = 1'b0;
    end else if (bus.trip_ack) begin
      m_accum = 0; m_trip = 1'b0; m_pickup = 1'b0; m_win = 1'b0;
    end else begin
      busy_now = m_win && ((m_cyc - m_acc_cyc) <= 3);
      if (bus.rms_valid && busy_now) m_over = 1'b1;
      if (m_win && ((m_cyc - m_acc_cyc) == 2)) begin
        b = model_band(w_rms, w_ip);
        if (b == 0) m_accum = (m_accum > RESET_DEC) ? m_accum - RESET_DEC : 0;
        else        m_accum = (m_accum + incr_tab[b] > ACC_MAXI) ? ACC_MAXI : m_accum + incr_tab[b];
        m_pickup = (b != 0);
        if (m_accum >= (w_tms + 1) * 64) m_trip = 1'b1;
      end
      if (bus.rms_valid && !busy_now) begin
        m_win = 1'b1; m_acc_cyc = m_cyc;
        w_rms = int'(bus.rms_value); w_ip = int'(bus.I_p); w_tms = int'(bus.tms);
      end
    end
    m_busy = m_win && ((m_cyc - m_acc_cyc) <= 2);
  end

  // Cycle-by-cycle comparison of every output against the model.
  always @(posedge clk_master) begin
    #1;
    chk("cyc trip_signal", 32'(bus.trip_signal), 32'(m_trip));
    chk("cyc pickup",      32'(bus.pickup),      32'(m_pickup));
    chk("cyc accum",       32'(bus.accum),       32'(m_accum));
    chk("cyc busy",        32'(bus.busy),        32'(m_busy));
    chk("cyc overrun",     32'(bus.overrun),     32'(m_over));
  end

  // ---------------- stimulus helpers ----------------
  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] mdl, input logic [31:0] exp);
    chk(name, act, exp);
    chk({"model ", name}, mdl, exp);
  endtask

  task automatic window(input logic [15:0] r, input logic [15:0] p, input logic [3:0] t);
    @(negedge clk_master);
    bus.rms_valid = 1'b1; bus.rms_value = r; bus.I_p = p; bus.tms = t;
    @(negedge clk_master);
    bus.rms_valid = 1'b0;
    repeat (3) @(negedge clk_master);
  endtask

  task automatic ack();
    @(negedge clk_master);
    bus.trip_ack = 1'b1;
    @(negedge clk_master);
    bus.trip_ack = 1'b0;
  endtask

  initial begin
    int p, r;
    bus.rms_valid = 1'b0; bus.rms_value = 16'd0; bus.I_p = 16'd0; bus.tms = 4'd0;
    bus.trip_ack = 1'b0; reset = 1'b0;
    repeat (3) @(negedge clk_master);
    lit("rst accum",   32'(bus.accum),       32'(m_accum),  32'd0);
    lit("rst trip",    32'(bus.trip_signal), 32'(m_trip),   32'd0);
    lit("rst pickup",  32'(bus.pickup),      32'(m_pickup), 32'd0);
    lit("rst busy",    32'(bus.busy),        32'(m_busy),   32'd0);
    lit("rst overrun", 32'(bus.overrun),     32'(m_over),   32'd0);
    reset = 1'b1;

    // Sub-pickup current never accumulates.
    repeat (10) window(16'd1414, 16'd2000, 4'd0);
    lit("subpk pickup", 32'(bus.pickup),      32'(m_pickup), 32'd0);
    lit("subpk accum",  32'(bus.accum),       32'(m_accum),  32'd0);
    lit("subpk trip",   32'(bus.trip_signal), 32'(m_trip),   32'd0);

    // Band 1: one count per window, trip on the 64th at n+3.
    repeat (63) window(16'd2828, 16'd2000, 4'd0);
    lit("b1 accum63",  32'(bus.accum),       32'(m_accum),  32'd63);
    lit("b1 trip63",   32'(bus.trip_signal), 32'(m_trip),   32'd0);
    lit("b1 pickup",   32'(bus.pickup),      32'(m_pickup), 32'd1);
    @(negedge clk_master);
    bus.rms_valid = 1'b1; bus.rms_value = 16'd2828; bus.I_p = 16'd2000; bus.tms = 4'd0;
    @(negedge clk_master);
    bus.rms_valid = 1'b0;
    @(negedge clk_master);
    lit("b1 trip n+2", 32'(bus.trip_signal), 32'(m_trip),  32'd0);
    @(negedge clk_master);
    lit("b1 trip n+3", 32'(bus.trip_signal), 32'(m_trip),  32'd1);
    lit("b1 accum64",  32'(bus.accum),       32'(m_accum), 32'd64);
    @(negedge clk_master);
    ack();
    lit("ack trip",   32'(bus.trip_signal), 32'(m_trip),   32'd0);
    lit("ack accum",  32'(bus.accum),       32'(m_accum),  32'd0);
    lit("ack pickup", 32'(bus.pickup),      32'(m_pickup), 32'd0);

    // Band 5 trips on the first window; band 0 decay keeps the trip latched.
    window(16'd16000, 16'd2000, 4'd0);
    lit("b5 accum", 32'(bus.accum),       32'(m_accum), 32'd64);
    lit("b5 trip",  32'(bus.trip_signal), 32'(m_trip),  32'd1);
    window(16'd1000, 16'd2000, 4'd0);
    lit("hold accum",  32'(bus.accum),       32'(m_accum),  32'd60);
    lit("hold trip",   32'(bus.trip_signal), 32'(m_trip),   32'd1);
    lit("hold pickup", 32'(bus.pickup),      32'(m_pickup), 32'd0);

    // Acknowledge wins over a coincident strobe, without overrun.
    @(negedge clk_master);
    bus.trip_ack = 1'b1; bus.rms_valid = 1'b1; bus.rms_value = 16'd16000;
    @(negedge clk_master);
    bus.trip_ack = 1'b0; bus.rms_valid = 1'b0;
    lit("ackv trip",    32'(bus.trip_signal), 32'(m_trip),  32'd0);
    lit("ackv accum",   32'(bus.accum),       32'(m_accum), 32'd0);
    lit("ackv overrun", 32'(bus.overrun),     32'(m_over),  32'd0);
    lit("ackv busy",    32'(bus.busy),        32'(m_busy),  32'd0);

    // Decay from 40 in steps of 4, flooring at 0.
    repeat (2) window(16'd8000, 16'd2000, 4'd15);
    lit("dec start", 32'(bus.accum), 32'(m_accum), 32'd40);
    window(16'd1000, 16'd2000, 4'd15);
    lit("dec 36", 32'(bus.accum), 32'(m_accum), 32'd36);
    repeat (8) window(16'd1000, 16'd2000, 4'd15);
    lit("dec 4", 32'(bus.accum), 32'(m_accum), 32'd4);
    window(16'd1000, 16'd2000, 4'd15);
    lit("dec 0", 32'(bus.accum), 32'(m_accum), 32'd0);
    window(16'd1000, 16'd2000, 4'd15);
    lit("dec floor", 32'(bus.accum),       32'(m_accum), 32'd0);
    lit("dec trip",  32'(bus.trip_signal), 32'(m_trip),  32'd0);

    // Odd pick-up: 1.5x threshold truncates, so 4 vs I_p=3 is band 2.
    window(16'd4, 16'd3, 4'd15);
    lit("odd ip accum", 32'(bus.accum), 32'(m_accum), 32'd3);
    ack();

    // tms=15 threshold 1024, then saturation at the top of the accumulator.
    repeat (15) window(16'd16000, 16'd2000, 4'd15);
    lit("tms15 accum960", 32'(bus.accum),       32'(m_accum), 32'd960);
    lit("tms15 trip0",    32'(bus.trip_signal), 32'(m_trip),  32'd0);
    window(16'd16000, 16'd2000, 4'd15);
    lit("tms15 accum1024", 32'(bus.accum),       32'(m_accum), 32'd1024);
    lit("tms15 trip1",     32'(bus.trip_signal), 32'(m_trip),  32'd1);
    repeat (1009) window(16'd16000, 16'd2000, 4'd15);
    lit("sat accum", 32'(bus.accum), 32'(m_accum), 32'd65535);
    ack();

    // Strobes two cycles apart: second dropped, overrun sticky.
    @(negedge clk_master);
    bus.rms_valid = 1'b1; bus.rms_value = 16'd2828; bus.I_p = 16'd2000; bus.tms = 4'd0;
    @(negedge clk_master);
    bus.rms_valid = 1'b0;
    @(negedge clk_master);
    bus.rms_valid = 1'b1;
    @(negedge clk_master);
    bus.rms_valid = 1'b0;
    repeat (4) @(negedge clk_master);
    lit("ovr flag",  32'(bus.overrun), 32'(m_over),  32'd1);
    lit("ovr accum", 32'(bus.accum),   32'(m_accum), 32'd1);
    ack();
    lit("ovr sticky", 32'(bus.overrun), 32'(m_over), 32'd1);

    // Reset in CLASSIFY aborts the window.
    window(16'd8000, 16'd2000, 4'd15);
    lit("abort pre", 32'(bus.accum), 32'(m_accum), 32'd20);
    @(negedge clk_master);
    bus.rms_valid = 1'b1;
    @(negedge clk_master);
    bus.rms_valid = 1'b0;
    @(negedge clk_master);
    reset = 1'b0;
    @(negedge clk_master);
    lit("abort accum",   32'(bus.accum),       32'(m_accum),  32'd0);
    lit("abort busy",    32'(bus.busy),        32'(m_busy),   32'd0);
    lit("abort trip",    32'(bus.trip_signal), 32'(m_trip),   32'd0);
    lit("abort pickup",  32'(bus.pickup),      32'(m_pickup), 32'd0);
    lit("abort overrun", 32'(bus.overrun),     32'(m_over),   32'd0);
    reset = 1'b1;

    // Randomised traffic with threshold-edge currents, acks and resets.
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk_master);
      case ($urandom_range(0, 7))
        0:       p = 0;
        1:       p = 1;
        2:       p = 3;
        default: p = int'($urandom_range(1, 8000));
      endcase
      case ($urandom_range(0, 10))
        0:       r = p - 1;
        1:       r = p;
        2:       r = p + p / 2 - 1;
        3:       r = p + p / 2;
        4:       r = 2 * p - 1;
        5:       r = 2 * p;
        6:       r = 4 * p - 1;
        7:       r = 4 * p;
        8:       r = 8 * p - 1;
        9:       r = 8 * p;
        default: r = int'($urandom_range(0, 65535));
      endcase
      if (r < 0) r = 0;
      if (r > 65535) r = 65535;
      bus.rms_value = 16'(r);
      bus.I_p       = 16'(p);
      bus.tms       = 4'($urandom_range(0, 3));
      bus.rms_valid = ($urandom_range(0, 2) == 0);
      bus.trip_ack  = ($urandom_range(0, 59) == 0);
      reset         = ($urandom_range(0, 299) != 0);
    end
    @(negedge clk_master);
    bus.rms_valid = 1'b0; bus.trip_ack = 1'b0; reset = 1'b1;
    repeat (6) @(negedge clk_master);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
